// File: rtl/rr_arb_pkg.sv
// Shared constants and FSM state type for the round-robin mux-select arbiter.
package rr_arb_pkg;

  localparam int N_CH_DEF  = 8;
  localparam int SEL_W_DEF = $clog2(N_CH_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set bit of req_vec at or after ptr,
// wrapping past N_CH-1. Built as rotate / priority-encode / un-rotate.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req_vec,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [2*N_CH-1:0] dbl_s;
  logic [N_CH-1:0]   rot_s;
  logic [SEL_W-1:0]  off_s;
  logic [SEL_W:0]    sum_s;

  // rotate so ptr lands on bit 0, take lowest set bit, then map back to a channel index
  always_comb begin
    dbl_s = {req_vec, req_vec} >> ptr;
    rot_s = dbl_s[N_CH-1:0];
    off_s = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      off_s = rot_s[i] ? SEL_W'(i) : off_s;
    end
    sum_s = {1'b0, off_s} + {1'b0, ptr};
    if (sum_s >= (SEL_W+1)'(N_CH)) begin
      idx = SEL_W'(sum_s - (SEL_W+1)'(N_CH));
    end else begin
      idx = sum_s[SEL_W-1:0];
    end
    found = |req_vec;
  end

endmodule

// File: rtl/rr_mux_select_arbiter.sv
// Round-robin arbiter driving the 8:1 mux select with valid/ready and one-cycle ack.
// Optional fixed top priority for channel 0 when RR_ARB_HIPRI_EN is defined.
module rr_mux_select_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  req,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  grant,
  output logic             out_valid,
  output logic [N_CH-1:0]  ack
);

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_CH-1:0]  grant_q, grant_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             handshake_s;
  logic [SEL_W-1:0] ptr_adv_s;
  logic [SEL_W-1:0] ptr_hs_s;
  logic [N_CH-1:0]  elig_s;
  logic [SEL_W-1:0] start_s;
  logic             pick_found_s;
  logic [SEL_W-1:0] pick_idx_s;
  logic             win_found_s;
  logic [SEL_W-1:0] win_idx_s;
  logic [N_CH-1:0]  win_onehot_s;

  // handshake detection and the request set / start index offered to the picker
  always_comb begin
    handshake_s = (state_q == HOLD) && valid_q && out_ready;
    if (sel_q == SEL_W'(N_CH - 1)) begin
      ptr_adv_s = '0;
    end else begin
      ptr_adv_s = sel_q + SEL_W'(1);
    end
`ifdef RR_ARB_HIPRI_EN
    // channel 0 only ever wins through the override, so its grants leave the rotation alone
    if (sel_q == '0) begin
      ptr_hs_s = ptr_q;
    end else begin
      ptr_hs_s = ptr_adv_s;
    end
`else
    ptr_hs_s = ptr_adv_s;
`endif
    if (state_q == IDLE) begin
      elig_s  = req;
      start_s = ptr_q;
    end else if (handshake_s) begin
      elig_s  = req & ~grant_q;
      start_s = ptr_hs_s;
    end else begin
      elig_s  = '0;
      start_s = ptr_q;
    end
  end

  rr_pick #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_pick (
    .req_vec (elig_s),
    .ptr     (start_s),
    .found   (pick_found_s),
    .idx     (pick_idx_s)
  );

  // winner selection, with the optional channel-0 override
  always_comb begin
    win_found_s = pick_found_s;
`ifdef RR_ARB_HIPRI_EN
    if (elig_s[0]) begin
      win_idx_s = '0;
    end else begin
      win_idx_s = pick_idx_s;
    end
`else
    win_idx_s = pick_idx_s;
`endif
    win_onehot_s            = '0;
    win_onehot_s[win_idx_s] = 1'b1;
  end

  // FSM next state and next register values
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (win_found_s) begin
          sel_d   = win_idx_s;
          grant_d = win_onehot_s;
          valid_d = 1'b1;
          state_d = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (handshake_s) begin
          ptr_d = ptr_hs_s;
          if (win_found_s) begin
            sel_d   = win_idx_s;
            grant_d = win_onehot_s;
            state_d = HOLD;
          end else begin
            valid_d = 1'b0;
            grant_d = '0;
            state_d = IDLE;
          end
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        valid_d = 1'b0;
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // state, pointer and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign sel       = sel_q;
  assign grant     = grant_q;
  assign out_valid = valid_q;
  assign ack       = handshake_s ? grant_q : '0;

endmodule

// File: tb/tb_rr_mux_select_arbiter.sv
// Directed and random bench for rr_mux_select_arbiter against a behavioural arbitration model.
module tb_rr_mux_select_arbiter;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       out_ready;
  logic [2:0] sel;
  logic [7:0] grant;
  logic       out_valid;
  logic [7:0] ack;

  int checks = 0;
  int errors = 0;

  logic       m_valid;
  logic [2:0] m_sel;
  logic [2:0] m_ptr;

  always #5 clk = ~clk;

  rr_mux_select_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
    .sel       (sel),
    .grant     (grant),
    .out_valid (out_valid),
    .ack       (ack)
  );

  function automatic logic [7:0] oh(input logic [2:0] i);
    logic [7:0] one;
    one = 8'h01;
    return one << i;
  endfunction

  // first requester found walking upward from start, wrapping
  function automatic logic [2:0] ref_pick(input logic [7:0] mask, input logic [2:0] start);
    int c;
`ifdef RR_ARB_HIPRI_EN
    if (mask[0]) return 3'd0;
`endif
    for (int j = 0; j < N; j++) begin
      c = (int'(start) + j) % N;
      if (mask[c]) return 3'(c);
    end
    return 3'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_sel   = 3'd0;
    m_ptr   = 3'd0;
  endtask

  task automatic model_adv(input logic [7:0] r, input logic rdy);
    logic [7:0] e;
    if (!m_valid) begin
      if (r != 8'h00) begin
        m_sel   = ref_pick(r, m_ptr);
        m_valid = 1'b1;
      end
    end else if (rdy) begin
`ifdef RR_ARB_HIPRI_EN
      if (m_sel != 3'd0) m_ptr = 3'((int'(m_sel) + 1) % N);
`else
      m_ptr = 3'((int'(m_sel) + 1) % N);
`endif
      e = r & ~oh(m_sel);
      if (e != 8'h00) m_sel = ref_pick(e, m_ptr);
      else m_valid = 1'b0;
    end
  endtask

  // apply inputs at the falling edge, check everything, advance one clock
  task automatic step(input logic [7:0] r, input logic rdy);
    req = r;
    out_ready = rdy;
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("sel", 32'(sel), 32'(m_sel));
    chk("grant", 32'(grant), 32'(m_valid ? oh(m_sel) : 8'h00));
    chk("ack", 32'(ack), 32'((m_valid && rdy) ? oh(m_sel) : 8'h00));
    model_adv(r, rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  // reset asserted between edges must clear outputs before any clock edge
  task automatic do_reset();
    req = 8'hFF;
    out_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    req = 8'h00;
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = 8'h00;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    chk("por_valid", 32'(out_valid), 32'd0);
    chk("por_grant", 32'(grant), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // single request, accepted immediately, then released
    do_reset();
    step(8'h01, 1'b1);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_sel", 32'(sel), 32'd0);
    step(8'h00, 1'b1);
    chk("single_drop", 32'(out_valid), 32'd0);

    // all channels requesting, consumer always ready
    do_reset();
    step(8'hFF, 1'b1);
    chk("walk_sel0", 32'(sel), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      step(8'hFF, 1'b1);
`ifndef RR_ARB_HIPRI_EN
      chk("walk_sel", 32'(sel), 32'(k % N));
`endif
    end

    // backpressure holds the grant stable
    do_reset();
    step(8'h24, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(8'h24, 1'b0);
      chk("bp_sel", 32'(sel), 32'd2);
      chk("bp_grant", 32'(grant), 32'h04);
    end
    step(8'h24, 1'b1);
    chk("bp_next_sel", 32'(sel), 32'd5);
    step(8'h20, 1'b1);

    // pointer wrap from channel 7 back to channel 0
    do_reset();
    step(8'h40, 1'b0);
    chk("wrap_sel6", 32'(sel), 32'd6);
    step(8'h81, 1'b1);
`ifdef RR_ARB_HIPRI_EN
    chk("wrap_first", 32'(sel), 32'd0);
`else
    chk("wrap_first", 32'(sel), 32'd7);
`endif
    step(8'h81, 1'b1);
`ifdef RR_ARB_HIPRI_EN
    chk("wrap_second", 32'(sel), 32'd7);
`else
    chk("wrap_second", 32'(sel), 32'd0);
`endif
    step(8'h00, 1'b1);

    // channel 0 against channel 3 with the pointer at 3
    do_reset();
    step(8'h04, 1'b1);
    step(8'h09, 1'b1);
`ifdef RR_ARB_HIPRI_EN
    chk("hipri_first", 32'(sel), 32'd0);
`else
    chk("hipri_first", 32'(sel), 32'd3);
`endif
    step(8'h09, 1'b1);
`ifdef RR_ARB_HIPRI_EN
    chk("hipri_second", 32'(sel), 32'd3);
`else
    chk("hipri_second", 32'(sel), 32'd0);
`endif
    step(8'h00, 1'b1);
    step(8'h00, 1'b0);

    // random traffic with one mid-run reset
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if (k == 300) do_reset();
      step(8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
